// File: rtl/i2c_codec_target.sv
// I2C write-only target for the audio codec control port: receives address + two
// data bytes, ACKs each, and commits a 7-bit register address / 9-bit value.
module i2c_codec_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [6:0] reg_addr,
   output logic [8:0] reg_data,
   output logic       reg_wr,
   output logic       busy,
   output logic       abort
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ADDR      = 3'd1;
   localparam logic [2:0] ACK_A     = 3'd2;
   localparam logic [2:0] BYTE1     = 3'd3;
   localparam logic [2:0] ACK1      = 3'd4;
   localparam logic [2:0] BYTE2     = 3'd5;
   localparam logic [2:0] ACK2      = 3'd6;
   localparam logic [2:0] WAIT_STOP = 3'd7;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_dly_q, sda_dly_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   logic [2:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] byte1_q, byte1_d;
   logic       full_q, full_d;
   logic       matched_q, matched_d;
   logic       sda_oe_q, sda_oe_d;
   logic [6:0] reg_addr_q, reg_addr_d;
   logic [8:0] reg_data_q, reg_data_d;
   logic       reg_wr_q, reg_wr_d;
   logic       abort_q, abort_d;
   logic [7:0] shift_next;

   // Synchronizers reset to 1 so an idle bus produces no spurious edges
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
         sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_dly_q;
   assign scl_fall  = ~scl_s & scl_dly_q;
   assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
   assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
   assign shift_next = {shift_q[6:0], sda_s};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      byte1_d    = byte1_q;
      full_d     = full_q;
      matched_d  = matched_q;
      sda_oe_d   = sda_oe_q;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      reg_wr_d   = 1'b0;
      abort_d    = 1'b0;
      if (start_det) begin
         state_d  = ADDR;
         cnt_d    = 3'd7;
         full_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else if (stop_det) begin
         abort_d   = matched_q && (state_q != IDLE) && (state_q != WAIT_STOP);
         state_d   = IDLE;
         full_d    = 1'b0;
         matched_d = 1'b0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ACK_A, ACK1, ACK2: begin
               // Falling edge ending the ninth clock releases SDA
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = 3'd7;
                  case (state_q)
                     ACK_A:   state_d = BYTE1;
                     ACK1:    state_d = BYTE2;
                     default: begin
                        state_d    = WAIT_STOP;
                        reg_addr_d = byte1_q[7:1];
                        reg_data_d = {byte1_q[0], shift_q};
                        reg_wr_d   = 1'b1;
                     end
                  endcase
               end
            end
            default: begin
               if (scl_rise && !full_q) begin
                  shift_d = shift_next;
                  if (cnt_q == 3'd0) full_d = 1'b1;
                  else cnt_d = cnt_q - 3'd1;
                  if (state_q == ADDR && cnt_q == 3'd0 && shift_next != {DEV_ADDR, 1'b0}) begin
                     state_d   = IDLE;
                     full_d    = 1'b0;
                     matched_d = 1'b0;
                  end
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  cnt_d  = 3'd7;
                  case (state_q)
                     ADDR: begin
                        state_d   = ACK_A;
                        sda_oe_d  = 1'b1;
                        matched_d = 1'b1;
                     end
                     BYTE1: begin
                        state_d  = ACK1;
                        byte1_d  = shift_q;
                        sda_oe_d = 1'b1;
                     end
                     BYTE2: begin
                        state_d  = ACK2;
                        sda_oe_d = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd7;
         shift_q    <= 8'h00;
         byte1_q    <= 8'h00;
         full_q     <= 1'b0;
         matched_q  <= 1'b0;
         sda_oe_q   <= 1'b0;
         reg_addr_q <= 7'h00;
         reg_data_q <= 9'h000;
         reg_wr_q   <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         byte1_q    <= byte1_d;
         full_q     <= full_d;
         matched_q  <= matched_d;
         sda_oe_q   <= sda_oe_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         reg_wr_q   <= reg_wr_d;
         abort_q    <= abort_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign reg_addr = reg_addr_q;
   assign reg_data = reg_data_q;
   assign reg_wr   = reg_wr_q;
   assign abort    = abort_q;
   assign busy     = (state_q != IDLE);

endmodule
